// File: rtl/spi_flash_cmd_engine.sv
// SPI flash command/readback engine.
// Shifts command words from a 32-bit write buffer out MSB-first, or sends the
// read command held in word 0 and streams BS_NBITS flash bits to the
// serial-config data line, one bit per clk.
`timescale 1ns/1ps
module spi_flash_cmd_engine #(
  parameter int          WBUF_WORDS = 128,
  parameter logic [31:0] BS_NBITS   = 32'd30_606_304
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          prog_chan_in_progress,
  input  logic                          store_flash_command,
  input  logic [$clog2(WBUF_WORDS)-1:0] wbuf_address,
  input  logic [31:0]                   flash_command,
  input  logic [11:0]                   flash_wr_nBits,
  input  logic                          send_write_command,
  input  logic                          read_bitstream,
  output logic                          end_write_command,
  output logic                          end_bitstream,
  output logic                          bitstream,
  output logic                          busy,
  output logic                          spi_cs_n,
  output logic                          spi_sck_en,
  output logic                          spi_mosi,
  input  logic                          spi_miso
);

  localparam int AW = $clog2(WBUF_WORDS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_SHIFT = 3'd1;
  localparam logic [2:0] WR_END   = 3'd2;
  localparam logic [2:0] RD_CMD   = 3'd3;
  localparam logic [2:0] RD_DATA  = 3'd4;
  localparam logic [2:0] RD_END   = 3'd5;

  logic [31:0]   wbuf [WBUF_WORDS];
  logic [2:0]    state;
  logic [31:0]   shifter;   // bits still to go out after the one on spi_mosi
  logic [31:0]   bit_cnt;   // index of the bit currently presented
  logic [AW-1:0] word_idx;
  logic [AW-1:0] word_nxt;
  logic [11:0]   nbits_q;

  assign busy     = (state != IDLE);
  assign word_nxt = (word_idx == AW'(WBUF_WORDS - 1)) ? '0 : word_idx + 1'b1;

  // Command buffer: written only while idle so a transfer never sees it change.
  always_ff @(posedge clk) begin
    if (store_flash_command && state == IDLE)
      wbuf[wbuf_address] <= flash_command;
  end

  // Transfer FSM; all pin outputs are registered so they change on clk edges only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      shifter           <= '0;
      bit_cnt           <= '0;
      word_idx          <= '0;
      nbits_q           <= '0;
      spi_cs_n          <= 1'b1;
      spi_sck_en        <= 1'b0;
      spi_mosi          <= 1'b0;
      bitstream         <= 1'b1;
      end_write_command <= 1'b0;
      end_bitstream     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (prog_chan_in_progress && (send_write_command || read_bitstream)) begin
            // Bit 0 goes straight onto mosi so it is visible the next cycle.
            state      <= send_write_command ? WR_SHIFT : RD_CMD;
            nbits_q    <= flash_wr_nBits;
            spi_mosi   <= wbuf[0][31];
            shifter    <= {wbuf[0][30:0], 1'b0};
            bit_cnt    <= '0;
            word_idx   <= '0;
            spi_cs_n   <= 1'b0;
            spi_sck_en <= 1'b1;
          end
        end
        WR_SHIFT: begin
          if (bit_cnt == {20'd0, nbits_q}) begin
            state             <= WR_END;
            spi_cs_n          <= 1'b1;
            spi_sck_en        <= 1'b0;
            spi_mosi          <= 1'b0;
            end_write_command <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 32'd1;
            if (bit_cnt[4:0] == 5'd31) begin
              // Word boundary: next word comes straight from the buffer.
              word_idx <= word_nxt;
              spi_mosi <= wbuf[word_nxt][31];
              shifter  <= {wbuf[word_nxt][30:0], 1'b0};
            end else begin
              spi_mosi <= shifter[31];
              shifter  <= {shifter[30:0], 1'b0};
            end
          end
        end
        WR_END: begin
          if (!send_write_command) begin
            state             <= IDLE;
            end_write_command <= 1'b0;
          end
        end
        RD_CMD: begin
          if (bit_cnt[4:0] == 5'd31) begin
            // CS stays low: data phase follows the last address bit directly.
            state    <= RD_DATA;
            spi_mosi <= 1'b0;
            bit_cnt  <= '0;
          end else begin
            bit_cnt  <= bit_cnt + 32'd1;
            spi_mosi <= shifter[31];
            shifter  <= {shifter[30:0], 1'b0};
          end
        end
        RD_DATA: begin
          bitstream <= spi_miso;
          if (bit_cnt == BS_NBITS - 32'd1) begin
            state         <= RD_END;
            spi_cs_n      <= 1'b1;
            spi_sck_en    <= 1'b0;
            end_bitstream <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 32'd1;
          end
        end
        RD_END: begin
          // The final sampled bit is shown for one cycle, then the line idles high.
          bitstream <= 1'b1;
          if (!read_bitstream) begin
            state         <= IDLE;
            end_bitstream <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
